// File: rtl/fpu_pkg.sv
// Shared types and default widths for the sequential floating-point adder.
package fpu_pkg;

  localparam int unsigned FPU_EXP_W = 4;
  localparam int unsigned FPU_MAN_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } fpu_state_e;

  typedef enum logic {
    SHIFT_RIGHT = 1'b0,
    SHIFT_LEFT  = 1'b1
  } shift_dir_e;

  typedef struct packed {
    logic [FPU_EXP_W-1:0] exp;
    logic [FPU_MAN_W-1:0] man;
  } fpu_operand_t;

endpackage

// File: rtl/fpu_shift_unit.sv
// Single-step mantissa shift with matching exponent adjust, plus zero/MSB flags
// of the unshifted mantissa.
module fpu_shift_unit
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = FPU_EXP_W,
  parameter int unsigned MAN_W = FPU_MAN_W
) (
  input  shift_dir_e       i_dir,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [MAN_W-1:0] i_man,
  output logic [EXP_W-1:0] o_exp_c,
  output logic [MAN_W-1:0] o_man_c,
  output logic             o_zero_c,
  output logic             o_msb_c
);

  // Right shift raises the exponent (alignment), left shift lowers it (normalization).
  always_comb begin
    o_exp_c = i_exp;
    o_man_c = i_man;
    if (i_dir == SHIFT_LEFT) begin
      o_man_c = i_man << 1;
      o_exp_c = i_exp - EXP_W'(1);
    end else begin
      o_man_c = i_man >> 1;
      o_exp_c = i_exp + EXP_W'(1);
    end
  end

  assign o_zero_c = (i_man == '0);
  assign o_msb_c  = i_man[MAN_W-1];

endmodule

// File: rtl/fpu_add_sequencer.sv
// Multi-cycle unsigned floating-point adder: capture, align, add, normalize, hold.
// Defining FPU_SEQ_PERF_EN adds op_count, a wrapping count of consumed results.
module fpu_add_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = FPU_EXP_W,
  parameter int unsigned MAN_W = FPU_MAN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [MAN_W-1:0] a_man,
  input  logic [MAN_W-1:0] b_man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] res_exp,
  output logic [MAN_W-1:0] res_man,
  output logic             overflow,
`ifdef FPU_SEQ_PERF_EN
  output logic [15:0]      op_count,
`endif
  output logic             busy
);

  fpu_state_e       r_state, w_state_next;
  logic [EXP_W-1:0] r_a_exp, r_b_exp, w_a_exp_next, w_b_exp_next;
  logic [MAN_W-1:0] r_a_man, r_b_man, w_a_man_next, w_b_man_next;
  logic [EXP_W-1:0] r_res_exp, w_res_exp_next;
  logic [MAN_W-1:0] r_res_man, w_res_man_next;
  logic             r_overflow, w_overflow_next;
  logic             r_in_ready, r_out_valid, r_busy;

  logic             w_a_larger, w_big_diff;
  logic [EXP_W-1:0] w_diff;
  logic [MAN_W:0]   w_sum;
  shift_dir_e       w_sh_dir;
  logic [EXP_W-1:0] w_sh_exp_in, w_sh_exp;
  logic [MAN_W-1:0] w_sh_man_in, w_sh_man;
  logic             w_sh_zero, w_sh_msb;

  assign w_a_larger = (r_a_exp > r_b_exp);
  assign w_diff     = w_a_larger ? (r_a_exp - r_b_exp) : (r_b_exp - r_a_exp);
  assign w_big_diff = (32'(w_diff) > MAN_W);
  assign w_sum      = (MAN_W+1)'(r_a_man) + (MAN_W+1)'(r_b_man);

  // Shared shifter: NORM shifts the accumulator left, ALIGN shifts the smaller operand right.
  always_comb begin
    w_sh_dir    = SHIFT_RIGHT;
    w_sh_exp_in = w_a_larger ? r_b_exp : r_a_exp;
    w_sh_man_in = w_a_larger ? r_b_man : r_a_man;
    if (r_state == NORM) begin
      w_sh_dir    = SHIFT_LEFT;
      w_sh_exp_in = r_a_exp;
      w_sh_man_in = r_a_man;
    end
  end

  fpu_shift_unit #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_shift (
    .i_dir    (w_sh_dir),
    .i_exp    (w_sh_exp_in),
    .i_man    (w_sh_man_in),
    .o_exp_c  (w_sh_exp),
    .o_man_c  (w_sh_man),
    .o_zero_c (w_sh_zero),
    .o_msb_c  (w_sh_msb)
  );

  // Next-state and datapath; operand A doubles as the accumulator after ADD.
  always_comb begin
    w_state_next    = r_state;
    w_a_exp_next    = r_a_exp;
    w_a_man_next    = r_a_man;
    w_b_exp_next    = r_b_exp;
    w_b_man_next    = r_b_man;
    w_res_exp_next  = r_res_exp;
    w_res_man_next  = r_res_man;
    w_overflow_next = r_overflow;
    unique case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_a_exp_next    = a_exp;
          w_a_man_next    = a_man;
          w_b_exp_next    = b_exp;
          w_b_man_next    = b_man;
          w_overflow_next = 1'b0;
          w_state_next    = ALIGN;
        end
      end
      ALIGN: begin
        if (r_a_exp == r_b_exp) begin
          w_state_next = ADD;
        end else if (w_big_diff) begin
          if (w_a_larger) begin
            w_b_man_next = '0;
            w_b_exp_next = r_a_exp;
          end else begin
            w_a_man_next = '0;
            w_a_exp_next = r_b_exp;
          end
        end else if (w_a_larger) begin
          w_b_man_next = w_sh_man;
          w_b_exp_next = w_sh_exp;
        end else begin
          w_a_man_next = w_sh_man;
          w_a_exp_next = w_sh_exp;
        end
      end
      ADD: begin
        w_a_man_next = w_sum[MAN_W-1:0];
        if (w_sum[MAN_W]) begin
          if (&r_a_exp) begin
            w_a_exp_next    = '1;
            w_a_man_next    = '1;
            w_overflow_next = 1'b1;
          end else begin
            w_a_man_next = w_sum[MAN_W:1];
            w_a_exp_next = r_a_exp + EXP_W'(1);
          end
        end
        w_state_next = NORM;
      end
      NORM: begin
        if (w_sh_zero) begin
          w_a_exp_next   = '0;
          w_res_exp_next = '0;
          w_res_man_next = r_a_man;
          w_state_next   = DONE;
        end else if (w_sh_msb || (r_a_exp == '0)) begin
          w_res_exp_next = r_a_exp;
          w_res_man_next = r_a_man;
          w_state_next   = DONE;
        end else begin
          w_a_man_next = w_sh_man;
          w_a_exp_next = w_sh_exp;
        end
      end
      DONE: begin
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_a_exp     <= '0;
      r_a_man     <= '0;
      r_b_exp     <= '0;
      r_b_man     <= '0;
      r_res_exp   <= '0;
      r_res_man   <= '0;
      r_overflow  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_a_exp     <= w_a_exp_next;
      r_a_man     <= w_a_man_next;
      r_b_exp     <= w_b_exp_next;
      r_b_man     <= w_b_man_next;
      r_res_exp   <= w_res_exp_next;
      r_res_man   <= w_res_man_next;
      r_overflow  <= w_overflow_next;
      r_in_ready  <= (w_state_next == IDLE);
      r_out_valid <= (w_state_next == DONE);
      r_busy      <= (w_state_next != IDLE);
    end
  end

`ifdef FPU_SEQ_PERF_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op_count <= '0;
    end else if ((r_state == DONE) && out_ready) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign res_exp   = r_res_exp;
  assign res_man   = r_res_man;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fpu_add_sequencer.sv
// Directed self-checking bench for fpu_add_sequencer (default 4/4 widths).
module tb_fpu_add_sequencer;
  import fpu_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a_exp, b_exp, a_man, b_man;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       res_exp, res_man;
  logic             overflow;
  logic             busy;
`ifdef FPU_SEQ_PERF_EN
  logic [15:0]      op_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  fpu_add_sequencer #(.EXP_W(4), .MAN_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_exp     (a_exp),
    .b_exp     (b_exp),
    .a_man     (a_man),
    .b_man     (b_man),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_exp   (res_exp),
    .res_man   (res_man),
    .overflow  (overflow),
`ifdef FPU_SEQ_PERF_EN
    .op_count  (op_count),
`endif
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Offers one pair from a negedge; lat counts clock edges from the accepting edge
  // (inclusive) until out_valid is first seen, capped at 40.
  task automatic run_op(input fpu_operand_t a, input fpu_operand_t b, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    a_exp = a.exp; a_man = a.man;
    b_exp = b.exp; b_man = b.man;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_exp = '0; a_man = '0; b_exp = '0; b_man = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%0b exp=1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b exp=0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", busy); else n_pass++;
    n_checks++; if (res_exp !== 4'd0) $display("FAIL rst_res_exp got=%0h exp=0", res_exp); else n_pass++;
    n_checks++; if (res_man !== 4'd0) $display("FAIL rst_res_man got=%0h exp=0", res_man); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow got=%0b exp=0", overflow); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_equal_exp();
    int lat;
    run_op('{exp: 4'd3, man: 4'b1000}, '{exp: 4'd3, man: 4'b1000}, lat);
    n_checks++; if (lat !== 4) $display("FAIL eq_latency got=%0d exp=4", lat); else n_pass++;
    n_checks++; if (res_exp !== 4'd4) $display("FAIL eq_res_exp got=%0h exp=4", res_exp); else n_pass++;
    n_checks++; if (res_man !== 4'b1000) $display("FAIL eq_res_man got=%b exp=1000", res_man); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL eq_overflow got=%0b exp=0", overflow); else n_pass++;
    n_checks++; if ((in_ready !== 1'b0) || (busy !== 1'b1)) $display("FAIL eq_done_flags in_ready=%0b busy=%0b exp 0/1", in_ready, busy); else n_pass++;
    consume();
  endtask

  task automatic test_align();
    int lat;
    run_op('{exp: 4'd5, man: 4'b1000}, '{exp: 4'd3, man: 4'b1000}, lat);
    n_checks++; if (lat !== 6) $display("FAIL align2_latency got=%0d exp=6", lat); else n_pass++;
    n_checks++; if (res_exp !== 4'd5) $display("FAIL align2_res_exp got=%0h exp=5", res_exp); else n_pass++;
    n_checks++; if (res_man !== 4'b1010) $display("FAIL align2_res_man got=%b exp=1010", res_man); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL align2_overflow got=%0b exp=0", overflow); else n_pass++;
    consume();
    run_op('{exp: 4'd9, man: 4'b1000}, '{exp: 4'd1, man: 4'b1111}, lat);
    n_checks++; if (lat !== 5) $display("FAIL alignbig_latency got=%0d exp=5", lat); else n_pass++;
    n_checks++; if (res_exp !== 4'd9) $display("FAIL alignbig_res_exp got=%0h exp=9", res_exp); else n_pass++;
    n_checks++; if (res_man !== 4'b1000) $display("FAIL alignbig_res_man got=%b exp=1000", res_man); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL alignbig_overflow got=%0b exp=0", overflow); else n_pass++;
    consume();
  endtask

  task automatic test_norm();
    int lat;
    run_op('{exp: 4'd4, man: 4'b0010}, '{exp: 4'd4, man: 4'b0001}, lat);
    n_checks++; if (lat !== 6) $display("FAIL norm2_latency got=%0d exp=6", lat); else n_pass++;
    n_checks++; if (res_exp !== 4'd2) $display("FAIL norm2_res_exp got=%0h exp=2", res_exp); else n_pass++;
    n_checks++; if (res_man !== 4'b1100) $display("FAIL norm2_res_man got=%b exp=1100", res_man); else n_pass++;
    consume();
    run_op('{exp: 4'd2, man: 4'b0000}, '{exp: 4'd2, man: 4'b0000}, lat);
    n_checks++; if (lat !== 4) $display("FAIL zero_latency got=%0d exp=4", lat); else n_pass++;
    n_checks++; if (res_exp !== 4'd0) $display("FAIL zero_res_exp got=%0h exp=0", res_exp); else n_pass++;
    n_checks++; if (res_man !== 4'b0000) $display("FAIL zero_res_man got=%b exp=0000", res_man); else n_pass++;
    consume();
  endtask

  task automatic test_overflow();
    int lat;
    run_op('{exp: 4'd15, man: 4'b1000}, '{exp: 4'd15, man: 4'b1000}, lat);
    n_checks++; if (lat !== 4) $display("FAIL ovf_latency got=%0d exp=4", lat); else n_pass++;
    n_checks++; if (res_exp !== 4'd15) $display("FAIL ovf_res_exp got=%0h exp=f", res_exp); else n_pass++;
    n_checks++; if (res_man !== 4'b1111) $display("FAIL ovf_res_man got=%b exp=1111", res_man); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%0b exp=1", overflow); else n_pass++;
    consume();
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_held_idle got=%0b exp=1", overflow); else n_pass++;
    run_op('{exp: 4'd1, man: 4'b1000}, '{exp: 4'd1, man: 4'b0000}, lat);
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_cleared got=%0b exp=0", overflow); else n_pass++;
    n_checks++; if (res_exp !== 4'd1) $display("FAIL ovf_next_res_exp got=%0h exp=1", res_exp); else n_pass++;
    n_checks++; if (res_man !== 4'b1000) $display("FAIL ovf_next_res_man got=%b exp=1000", res_man); else n_pass++;
    consume();
  endtask

  // Result must stay frozen in DONE, and a pair offered meanwhile must not be taken.
  task automatic test_done_hold();
    int lat;
    run_op('{exp: 4'd5, man: 4'b1000}, '{exp: 4'd3, man: 4'b1000}, lat);
    a_exp = 4'd7; a_man = 4'b1111; b_exp = 4'd7; b_man = 4'b1111;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL hold%0d_out_valid got=%0b exp=1", i, out_valid); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL hold%0d_in_ready got=%0b exp=0", i, in_ready); else n_pass++;
      n_checks++; if (res_exp !== 4'd5) $display("FAIL hold%0d_res_exp got=%0h exp=5", i, res_exp); else n_pass++;
      n_checks++; if (res_man !== 4'b1010) $display("FAIL hold%0d_res_man got=%b exp=1010", i, res_man); else n_pass++;
    end
    in_valid = 1'b0;
    consume();
    repeat (2) @(negedge clock);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL hold_after_in_ready got=%0b exp=1", in_ready); else n_pass++;
    n_checks++; if ((out_valid !== 1'b0) || (busy !== 1'b0)) $display("FAIL hold_after_idle out_valid=%0b busy=%0b exp 0/0", out_valid, busy); else n_pass++;
  endtask

  task automatic test_reset_mid_align();
    int seen;
    int lat;
    a_exp = 4'd5; a_man = 4'b1000; b_exp = 4'd3; b_man = 4'b1000;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before got=%0b exp=1", busy); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got=%0b exp=1", in_ready); else n_pass++;
    n_checks++; if ((out_valid !== 1'b0) || (busy !== 1'b0)) $display("FAIL mid_idle out_valid=%0b busy=%0b exp 0/0", out_valid, busy); else n_pass++;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL mid_no_result got=%0d exp=0", seen); else n_pass++;
    run_op('{exp: 4'd3, man: 4'b1000}, '{exp: 4'd3, man: 4'b1000}, lat);
    n_checks++; if (lat !== 4) $display("FAIL post_rst_latency got=%0d exp=4", lat); else n_pass++;
    n_checks++; if ((res_exp !== 4'd4) || (res_man !== 4'b1000)) $display("FAIL post_rst_res got=%0h/%b exp=4/1000", res_exp, res_man); else n_pass++;
    consume();
  endtask

  initial begin
    test_reset();
    test_equal_exp();
    test_align();
    test_norm();
    test_overflow();
    test_done_hold();
    test_reset_mid_align();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_add_sequencer.md
FPU_ADD_SEQUENCER -- requirements
Module: fpu_add_sequencer

Interface
REQ-001 Parameters (name, default, meaning): EXP_W, 4, exponent width; MAN_W, 4, mantissa width (explicit MSB, unsigned magnitude, no sign).
REQ-002 Ports (name direction width meaning): clock in 1 rising-edge clock; reset in 1 synchronous active-high reset.
REQ-003 in_valid in 1 operand pair offered; in_ready out 1 sequencer can accept.
REQ-004 a_exp, b_exp in EXP_W operand exponents; a_man, b_man in MAN_W operand mantissas.
REQ-005 out_valid out 1 result available; out_ready in 1 consumer takes result.
REQ-006 res_exp out EXP_W, res_man out MAN_W result; overflow out 1 exponent saturated; busy out 1 state != IDLE.
REQ-007 The block SHALL have one clock, clock, and a synchronous, active-high reset, reset.

Function
REQ-008 The FSM SHALL have states IDLE, ALIGN, ADD, NORM, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-009 IDLE: on in_valid&&in_ready, capture both operands; next state ALIGN; else stay.
REQ-010 ALIGN, per cycle: exponents equal -> ADD; diff d > MAN_W -> smaller operand's mantissa forced 0 and its exponent set to larger, stay ALIGN; otherwise smaller operand mantissa >>1, exponent +1. ALIGN lasts d+1 cycles (d<=MAN_W) or 2 cycles (d>MAN_W).
REQ-011 ADD (1 cycle): sum = a_man+b_man in MAN_W+1 bits; carry -> man = sum>>1, exp+1; carry with exp all-ones -> exp and man all-ones, overflow=1; next NORM.
REQ-012 NORM, per cycle: man==0 -> exp=0, go DONE; man MSB set or exp==0 -> go DONE; else man<<1, exp-1. NORM lasts k+1 cycles for k shifts.
REQ-013 DONE: res_exp/res_man/overflow SHALL be held stable while out_ready=0; on out_ready -> IDLE.
REQ-014 Minimum latency: out_valid asserted 4 cycles after the accepting edge (d=0, no carry shift, k=0).
REQ-015 in_valid in non-IDLE states SHALL be ignored; no operand capture until return to IDLE.
REQ-016 overflow SHALL clear on the next accepted operand pair.

Reset
REQ-017 Reset SHALL force state IDLE, res_exp=0, res_man=0, overflow=0, out_valid=0, busy=0, in_ready=1 after the reset edge.
REQ-018 Reset in any state (incl. mid-ALIGN/NORM or DONE with out_ready=0) SHALL abandon the operation; no out_valid for it.

Configuration
REQ-019 Macro FPU_SEQ_PERF_EN defined: extra port op_count out 16 counting DONE->IDLE handshakes, wraps 0xFFFF->0, reset to 0; undefined: port and counter absent, behaviour otherwise identical.

Structure
REQ-020 Package fpu_pkg SHALL hold the state enum type, an operand struct (exp, man) and default width constants.
REQ-021 Sub-module fpu_shift_unit SHALL implement the single-step shift/exponent adjust used by ALIGN and NORM (direction input, zero/MSB flags out).

Verification
REQ-022 a=(3,1000), b=(3,1000) -> res=(4,1000), overflow=0, out_valid exactly 4 cycles after accept.
REQ-023 a=(5,1000), b=(3,1000) -> b aligned to 0010, res=(5,1010), ALIGN occupies 3 cycles; a=(9,1000), b=(1,1111) -> res=(9,1000), ALIGN 2 cycles.
REQ-024 a=(4,0010), b=(4,0001) -> res=(2,1100) after 2 NORM shifts; a=(2,0000), b=(2,0000) -> res=(0,0000).
REQ-025 a=(15,1000), b=(15,1000) -> res=(15,1111), overflow=1; next pair (1,1000)+(1,0000) -> overflow=0.
REQ-026 out_ready held low 3 cycles in DONE -> outputs unchanged, in_ready=0; reset asserted during ALIGN -> next cycle IDLE, in_ready=1, out_valid=0, no result emitted.
